counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencing controller for one external N-bit universal up/down binary counter. Drives the counter's clear, load, enable, direction and load-data inputs, and watches its count value and min tick. Runs one-shot or auto-reload intervals with a fixed clock prescaler. Used as the timing engine behind lab timers, delays and periodic event generators.

Parameters:
N, 8, width of counter value, period and load data
PRESC, 1, clocks per counter enable pulse; must be >= 1; internal prescaler width is clog2(PRESC)+1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  latch config and begin interval; level sampled each clock
stop  input  1  abort to IDLE and clear counter
pause  input  1  level; freezes counting while high in RUN
reload  input  1  config: 1 = auto-reload, 0 = one-shot; latched on start
dir_up  input  1  config: 1 = count up 0->period, 0 = count down period->0; latched on start
period  input  N  interval length in counter steps; latched on start
cnt_q  input  N  counter current value
cnt_min_tick  input  1  counter value == 0
cnt_syn_clr  output  1  to counter syn_clr
cnt_load  output  1  to counter load
cnt_d  output  N  to counter d
cnt_en  output  1  to counter en
cnt_up  output  1  to counter up
busy  output  1  high in ARM, RUN, HOLD
done_tick  output  1  one-cycle pulse per terminal event

Behaviour:
- Reset (async, reset_n=0): state IDLE; period_r, dir_r, reload_r and prescaler = 0. Every output is 0 during reset and in IDLE, except where the stop rule applies.
- Outputs are combinational from state, latched regs and cnt_q; internal regs update on the rising clk edge only.
- States: IDLE, ARM, RUN, HOLD, DONE.
- Priority when inputs coincide: stop > start > pause.
- stop while not in IDLE:
  - cnt_syn_clr=1 in that same cycle.
  - Next state is IDLE; prescaler is cleared.
  - stop in IDLE has no effect.
- start in any state, with stop low:
  - Latch period, dir_up and reload.
  - Next state is ARM. This restarts an active interval.
- ARM, one cycle:
  - dir_r=0: cnt_load=1 and cnt_d=period_r.
  - dir_r=1: cnt_syn_clr=1 and cnt_d=0.
  - Prescaler is cleared. Next state is RUN.
- RUN:
  - cnt_up=dir_r.
  - terminal = cnt_min_tick when dir_r=0; terminal = (cnt_q==period_r) when dir_r=1.
  - When terminal is high:
    - done_tick=1 and cnt_en=0.
    - Next state is ARM if reload_r=1, else DONE.
  - Otherwise:
    - The prescaler increments each cycle and wraps at PRESC-1.
    - cnt_en=1 in the cycle the prescaler equals PRESC-1.
  - Latency: done_tick is asserted period*PRESC+1 cycles after the ARM cycle. Example: PRESC=1, period=3, down: ARM c1; q=3,2,1,0 in c2..c5; done_tick in c5.
  - period=0: terminal in the first RUN cycle. With reload=1, done_tick fires every 2 cycles.
  - Auto-reload period in cycles = period*PRESC+2, which includes the ARM cycle.
- HOLD:
  - Entered from RUN when pause=1 and terminal=0. If terminal=1, the terminal event wins.
  - cnt_en=0; prescaler and counter value are frozen; busy=1.
  - Returns to RUN when pause=0, resuming the prescaler phase unchanged.
- DONE:
  - busy=0, cnt_en=0; the counter holds its terminal value.
  - Stays in DONE until start or stop; pause is ignored.
- start is a level input: if held high, the controller re-enters ARM every cycle. Requesters pulse it for one cycle.
- cnt_up drives dir_r in every state. It is 0 in IDLE.
- Reset asserted mid-interval: immediate IDLE with all outputs 0. The external counter is not cleared by this block.

Optional Feature:
Macro EXPIRE_CNT_EN.
- Defined:
  - Adds output port expire_cnt (8 bits).
  - Increments on each done_tick and saturates at 255.
  - Cleared by reset and by stop. Not cleared by start.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- PRESC=1, period=3, dir_up=0, reload=0, one-cycle start:
  - cnt_load=1 and cnt_d=3 in the ARM cycle.
  - cnt_en high 3 cycles.
  - done_tick exactly once, 5 cycles after start is sampled.
  - Then DONE with busy=0.
- PRESC=4, period=2, dir_up=1, reload=1:
  - cnt_syn_clr in the ARM cycle.
  - cnt_en pulses every 4th cycle.
  - done_tick when cnt_q==2, repeating every 10 cycles for 3 intervals.
- Pause:
  - Pause held 5 cycles mid-RUN: cnt_en=0 and cnt_q frozen during the hold.
  - After release, done_tick is delayed by exactly 5 cycles versus the no-pause run.
- Stop and start together in RUN:
  - cnt_syn_clr=1 that cycle; next state IDLE; busy=0; no done_tick.
  - Start then restarts cleanly, with ARM in the cycle after start.
- period=0 with reload=1 and dir_up=0: done_tick every 2 cycles; cnt_en never asserted.
- With EXPIRE_CNT_EN defined:
  - 300 reload events give expire_cnt=255 (saturated).
  - stop gives expire_cnt=0.
  - Async reset mid-RUN drives all outputs to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external N-bit up/down counter: one-shot or auto-reload
// intervals with a fixed prescaler. Optional EXPIRE_CNT_EN adds a saturating expiry counter.
module counter_seq_ctrl #(
  parameter int N     = 8,
  parameter int PRESC = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         reload,
  input  logic         dir_up,
  input  logic [N-1:0] period,
  input  logic [N-1:0] cnt_q,
  input  logic         cnt_min_tick,
  output logic         cnt_syn_clr,
  output logic         cnt_load,
  output logic [N-1:0] cnt_d,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         busy,
  output logic         done_tick
`ifdef EXPIRE_CNT_EN
  ,
  output logic [7:0]   expire_cnt
`endif
);

  localparam int PW = $clog2(PRESC) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  typedef enum logic [2:0] {IDLE, ARM, RUN, HOLD, DONE} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    period_reg;
  logic            dir_reg;
  logic            reload_reg;
  logic [PW-1:0]   presc_reg, presc_next;
  logic            terminal;
  logic            latch_cfg;

  // Up-count ends on reaching the period; down-count ends on the counter's zero tick.
  assign terminal  = dir_reg ? (cnt_q == period_reg) : cnt_min_tick;
  assign latch_cfg = start && !stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      period_reg <= '0;
      dir_reg    <= 1'b0;
      reload_reg <= 1'b0;
      presc_reg  <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      if (latch_cfg) begin
        period_reg <= period;
        dir_reg    <= dir_up;
        reload_reg <= reload;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    cnt_syn_clr = 1'b0;
    cnt_load    = 1'b0;
    cnt_d       = '0;
    cnt_en      = 1'b0;
    cnt_up      = (state_reg != IDLE) ? dir_reg : 1'b0;
    busy        = (state_reg == ARM) || (state_reg == RUN) || (state_reg == HOLD);
    done_tick   = 1'b0;

    case (state_reg)
      ARM: begin
        if (dir_reg) begin
          cnt_syn_clr = 1'b1;
        end else begin
          cnt_load = 1'b1;
          cnt_d    = period_reg;
        end
        presc_next = '0;
        state_next = RUN;
      end
      RUN: begin
        if (terminal) begin
          done_tick  = 1'b1;
          state_next = reload_reg ? ARM : DONE;
        end else begin
          cnt_en     = (presc_reg == PRESC_LAST);
          presc_next = (presc_reg == PRESC_LAST) ? '0 : PW'(presc_reg + 1'b1);
          if (pause) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (!pause) begin
          state_next = RUN;
        end
      end
      default: ;
    endcase

    // Stop outranks start; it clears the counter and suppresses every other strobe.
    if (stop) begin
      if (state_reg != IDLE) begin
        state_next  = IDLE;
        presc_next  = '0;
        cnt_syn_clr = 1'b1;
        cnt_load    = 1'b0;
        cnt_d       = '0;
        cnt_en      = 1'b0;
        done_tick   = 1'b0;
      end
    end else if (start) begin
      state_next = ARM;
    end
  end

`ifdef EXPIRE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expire_cnt <= 8'd0;
    end else if (stop) begin
      expire_cnt <= 8'd0;
    end else if (done_tick && (expire_cnt != 8'hFF)) begin
      expire_cnt <= expire_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: PRESC=1 and PRESC=4 instances share stimulus,
// each driving its own behavioural counter. Covers EXPIRE_CNT_EN when defined.
module tb_counter_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start, stop, pause, reload, dir_up;
  logic [7:0] period;
  logic       model_clr;

  logic       syn_clr1, load1, en1, up1, busy1, done1;
  logic [7:0] d1, q1;
  logic       syn_clr4, load4, en4, up4, busy4, done4;
  logic [7:0] d4, q4;
`ifdef EXPIRE_CNT_EN
  logic [7:0] expire1, expire4;
`endif

  int total_checks = 0;
  int passed_checks = 0;
  int en_cnt, done_cnt, done_at, ref_at;

  counter_seq_ctrl #(.N(8), .PRESC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .reload(reload), .dir_up(dir_up), .period(period), .cnt_q(q1),
    .cnt_min_tick(q1 == 8'd0), .cnt_syn_clr(syn_clr1), .cnt_load(load1),
    .cnt_d(d1), .cnt_en(en1), .cnt_up(up1), .busy(busy1), .done_tick(done1)
`ifdef EXPIRE_CNT_EN
    , .expire_cnt(expire1)
`endif
  );

  counter_seq_ctrl #(.N(8), .PRESC(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .reload(reload), .dir_up(dir_up), .period(period), .cnt_q(q4),
    .cnt_min_tick(q4 == 8'd0), .cnt_syn_clr(syn_clr4), .cnt_load(load4),
    .cnt_d(d4), .cnt_en(en4), .cnt_up(up4), .busy(busy4), .done_tick(done4)
`ifdef EXPIRE_CNT_EN
    , .expire_cnt(expire4)
`endif
  );

  // External universal counters: syn_clr > load > en.
  always @(posedge clk) begin
    if (model_clr || syn_clr1) q1 <= 8'd0;
    else if (load1)            q1 <= d1;
    else if (en1)              q1 <= up1 ? q1 + 8'd1 : q1 - 8'd1;
  end

  always @(posedge clk) begin
    if (model_clr || syn_clr4) q4 <= 8'd0;
    else if (load4)            q4 <= d4;
    else if (en4)              q4 <= up4 ? q4 + 8'd1 : q4 - 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs === exp) passed_checks++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    stop = 1'b1;
    step();
    stop  = 1'b0;
    pause = 1'b0;
    step();
  endtask

  initial begin
    {start, stop, pause, reload, dir_up} = 5'b0;
    period    = 8'd0;
    reset_n   = 1'b0;
    model_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out1", 32'({syn_clr1, load1, d1, en1, up1, busy1, done1}), 32'd0);
    check("rst_out4", 32'({syn_clr4, load4, d4, en4, up4, busy4, done4}), 32'd0);
`ifdef EXPIRE_CNT_EN
    check("rst_expire", 32'(expire1), 32'd0);
`endif
    reset_n = 1'b1;
    step();
    model_clr = 1'b0;
    #1;
    check("idle_busy", 32'(busy1), 32'd0);
    $display("txn reset: outputs idle");

    // One-shot down-count, PRESC=1, period=3
    period = 8'd3; dir_up = 1'b0; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    en_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (i == 1) begin
        check("t1_load", 32'(load1), 32'd1);
        check("t1_d", 32'(d1), 32'd3);
        check("t1_busy_arm", 32'(busy1), 32'd1);
      end
      if (en1) en_cnt++;
      if (done1) begin done_cnt++; done_at = i; end
      if (i == 6) begin
        check("t1_busy_done", 32'(busy1), 32'd0);
        check("t1_q_hold", 32'(q1), 32'd0);
      end
      step();
    end
    check("t1_en_cnt", 32'(en_cnt), 32'd3);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_at", 32'(done_at), 32'd5);
    $display("txn one-shot: en_cnt=%0d done_cnt=%0d done_at=%0d", en_cnt, done_cnt, done_at);
    clear_all();

    // Auto-reload up-count, PRESC=4, period=2: 10-cycle intervals
    period = 8'd2; dir_up = 1'b1; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("t2_up", 32'(up4), 32'd1);
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) #1;
      check("t2_syn_clr", 32'(syn_clr4), 32'((i % 10) == 1));
      check("t2_en", 32'(en4), 32'(((i % 10) == 5) || ((i % 10) == 9)));
      check("t2_done", 32'(done4), 32'((i % 10) == 0));
      if ((i % 10) == 0) check("t2_q", 32'(q4), 32'd2);
      step();
    end
    $display("txn reload-up presc4: 3 intervals of 10 cycles");
    clear_all();

    // Pause: reference run, then the same run with pause high for 5 cycles
    period = 8'd6; dir_up = 1'b0; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0; ref_at = 0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      if (done1 && ref_at == 0) ref_at = i;
      step();
    end
    check("t3_ref_done_at", 32'(ref_at), 32'd8);
    clear_all();
    start = 1'b1;
    step();
    start = 1'b0; done_at = 0;
    for (int i = 1; i <= 16; i++) begin
      pause = (i >= 3) && (i <= 7);
      #1;
      if (done1 && done_at == 0) done_at = i;
      if (i >= 4 && i <= 8) begin
        check("t3_hold_en", 32'(en1), 32'd0);
        check("t3_hold_q", 32'(q1), 32'd4);
        check("t3_hold_busy", 32'(busy1), 32'd1);
      end
      step();
    end
    pause = 1'b0;
    check("t3_done_at", 32'(done_at), 32'd13);
    check("t3_delay", 32'(done_at - ref_at), 32'd5);
    $display("txn pause: ref_at=%0d paused_at=%0d", ref_at, done_at);
    clear_all();

    // Stop and start together in RUN, then a clean restart
    period = 8'd5; dir_up = 1'b0; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stop = 1'b1; start = 1'b1;
    #1;
    check("t4_syn_clr", 32'(syn_clr1), 32'd1);
    check("t4_done", 32'(done1), 32'd0);
    check("t4_en", 32'(en1), 32'd0);
    check("t4_load", 32'(load1), 32'd0);
    step();
    stop = 1'b0; start = 1'b0;
    #1;
    check("t4_idle_busy", 32'(busy1), 32'd0);
    check("t4_idle_clr", 32'(syn_clr1), 32'd0);
    check("t4_q_clr", 32'(q1), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("t4_rearm_load", 32'(load1), 32'd1);
    check("t4_rearm_d", 32'(d1), 32'd5);
    check("t4_rearm_busy", 32'(busy1), 32'd1);
    $display("txn stop+start: cleared and re-armed");
    clear_all();

    // period=0 with reload: done every 2 cycles, no enables
    period = 8'd0; dir_up = 1'b0; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      check("t5_done1", 32'(done1), 32'((i % 2) == 0));
      check("t5_load1", 32'(load1), 32'((i % 2) == 1));
      check("t5_en1", 32'(en1), 32'd0);
      check("t5_done4", 32'(done4), 32'((i % 2) == 0));
      check("t5_en4", 32'(en4), 32'd0);
      step();
    end
    $display("txn period0 reload: done every 2 cycles");
    clear_all();

`ifdef EXPIRE_CNT_EN
    #1;
    check("t6_expire_clr", 32'(expire1), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 600; i++) step();
    check("t6_expire_sat", 32'(expire1), 32'd255);
    check("t6_expire_sat4", 32'(expire4), 32'd255);
    stop = 1'b1;
    step();
    stop = 1'b0;
    #1;
    check("t6_expire_stop", 32'(expire1), 32'd0);
    $display("txn expire: saturated then cleared by stop");
    step();
`endif

    // Asynchronous reset mid-RUN drops every output before the next edge
    period = 8'd9; dir_up = 1'b1; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #1;
    check("t7_busy_pre", 32'(busy1), 32'd1);
    check("t7_up_pre", 32'(up1), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_out1", 32'({syn_clr1, load1, d1, en1, up1, busy1, done1}), 32'd0);
    check("t7_out4", 32'({syn_clr4, load4, d4, en4, up4, busy4, done4}), 32'd0);
`ifdef EXPIRE_CNT_EN
    check("t7_expire", 32'(expire1), 32'd0);
`endif
    $display("txn async reset: outputs dropped");
    step();
    reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
